// File: rtl/led_heartbeat_pkg.sv
// Shared mode encoding for the LED heartbeat array and its per-channel engine.
package led_heartbeat_pkg;

    typedef enum logic [1:0] {
        LED_MODE_OFF      = 2'd0,
        LED_MODE_ON       = 2'd1,
        LED_MODE_BLINK    = 2'd2,
        LED_MODE_ACTIVITY = 2'd3
    } led_mode_e;

    localparam int LED_MODE_W = 2;

    // LED level a channel shows on the edge where it enters a mode.
    function automatic logic entry_level(input led_mode_e mode);
        return mode == LED_MODE_ON;
    endfunction

endpackage

// File: rtl/led_heartbeat_channel.sv
// One LED channel: registered mode, tick counter and LED flop implementing
// OFF / ON / BLINK / ACTIVITY-stretch behaviour.
module led_heartbeat_channel
    import led_heartbeat_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  led_mode_e        mode,
    input  logic [CNT_W-1:0] period,
    input  logic             event_pulse,
    output logic             led
);

    led_mode_e        mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             led_q, led_d;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        mode_d = mode;
        cnt_d  = cnt_q;
        led_d  = led_q;

        if (mode != mode_q) begin
            cnt_d = '0;
            led_d = entry_level(mode);
        end else begin
            unique case (mode)
                LED_MODE_OFF: begin
                    cnt_d = '0;
                    led_d = 1'b0;
                end
                LED_MODE_ON: begin
                    cnt_d = '0;
                    led_d = 1'b1;
                end
                LED_MODE_BLINK: begin
                    if (tick) begin
                        if (cnt_q == period) begin
                            cnt_d = '0;
                            led_d = ~led_q;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                LED_MODE_ACTIVITY: begin
                    // A reload beats a coincident tick; a count of 0 or 1 ends the stretch.
                    if (event_pulse) begin
                        cnt_d = period;
                        led_d = 1'b1;
                    end else if (tick) begin
                        if (cnt_q > CNT_W'(1)) begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end else begin
                            cnt_d = '0;
                            led_d = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= LED_MODE_OFF;
            cnt_q  <= '0;
            led_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            led_q  <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_heartbeat_array.sv
// Bank of NUM_CH status-LED drivers sharing one prescaler, with a selectable spare LED.
// Define LED_HEARTBEAT_PWM_EN to add the dim input and a final PWM dimming stage.
module led_heartbeat_array
    import led_heartbeat_pkg::*;
#(
    parameter int NUM_CH       = 8,
    parameter int PRESCALE_W   = 20,
    parameter int PRESCALE_MAX = 83000,
    parameter int CNT_W        = 12,
    parameter int SEL_W        = 3
) (
    input  logic                      sys_clock_in,
    input  logic                      system_reset_in,
    input  logic [2*NUM_CH-1:0]       ch_mode,
    input  logic [CNT_W*NUM_CH-1:0]   ch_period,
    input  logic [NUM_CH-1:0]         ch_event,
    input  logic [SEL_W-1:0]          sel,
`ifdef LED_HEARTBEAT_PWM_EN
    input  logic [3:0]                dim,
`endif
    output logic [NUM_CH-1:0]         leds,
    output logic                      sel_led,
    output logic                      tick
);

    localparam logic [PRESCALE_W-1:0] PRE_TERM = PRESCALE_W'(PRESCALE_MAX);

    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic                  tick_q, tick_d;
    logic                  sel_led_q, sel_led_d;
    logic [NUM_CH-1:0]     led_w;

    always_comb begin
        tick_d    = (pre_cnt_q == PRE_TERM);
        pre_cnt_d = tick_d ? '0 : pre_cnt_q + PRESCALE_W'(1);
        sel_led_d = 1'b0;
        if (int'(sel) < NUM_CH) begin
            sel_led_d = led_w[sel];
        end
    end

    always_ff @(posedge sys_clock_in) begin
        if (system_reset_in) begin
            pre_cnt_q <= '0;
            tick_q    <= 1'b0;
            sel_led_q <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            tick_q    <= tick_d;
            sel_led_q <= sel_led_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_heartbeat_channel #(
            .CNT_W (CNT_W)
        ) u_channel (
            .clk         (sys_clock_in),
            .rst         (system_reset_in),
            .tick        (tick_q),
            .mode        (led_mode_e'(ch_mode[LED_MODE_W*i +: LED_MODE_W])),
            .period      (ch_period[CNT_W*i +: CNT_W]),
            .event_pulse (ch_event[i]),
            .led         (led_w[i])
        );
    end

`ifdef LED_HEARTBEAT_PWM_EN
    logic [3:0]        pwm_q, pwm_d;
    logic [NUM_CH-1:0] leds_q, leds_d;
    logic              sel_out_q, sel_out_d;
    logic              pwm_on;

    // Dimming gates the already-registered LEDs, costing one more cycle of latency.
    always_comb begin
        pwm_d     = pwm_q + 4'd1;
        pwm_on    = (pwm_q < dim);
        leds_d    = led_w & {NUM_CH{pwm_on}};
        sel_out_d = sel_led_q & pwm_on;
    end

    always_ff @(posedge sys_clock_in) begin
        if (system_reset_in) begin
            pwm_q     <= '0;
            leds_q    <= '0;
            sel_out_q <= 1'b0;
        end else begin
            pwm_q     <= pwm_d;
            leds_q    <= leds_d;
            sel_out_q <= sel_out_d;
        end
    end

    assign leds    = leds_q;
    assign sel_led = sel_out_q;
`else
    assign leds    = led_w;
    assign sel_led = sel_led_q;
`endif

    assign tick = tick_q;

endmodule
